// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain stage.
// Drain FSM states, skid-buffer depth and occupancy type.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam int BUF_DP = 3;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd3;

    localparam int DEF_DATA_WD = 8;
    localparam int DEF_CNT_WD  = 16;

    // true while the buffer can absorb one more word on top of
    // what is already stored plus the word still in flight
    function automatic logic has_room(occ_t occ, logic inflight);
        return (3'(occ) + 3'(inflight)) < 3'(BUF_DP);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus downstream valid/ready stream.
// master = drain stage, slave = FIFO and stream consumer.
interface fifo_rd_drain_if
    import fifo_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD
);

    logic               fifo_empty;
    logic [DATA_WD-1:0] fifo_rdata;
    logic               fifo_ren;
    logic               m_valid;
    logic               m_ready;
    logic [DATA_WD-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_ren,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_ren,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// 3-entry register buffer, strict FIFO order, head held in entry 0.
// Overfill drops the word and holds occupancy instead of wrapping.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DATA_WD-1:0] push_data,
    input  logic               pop,
    output occ_t               occ,
    output logic [DATA_WD-1:0] head
);

    logic [DATA_WD-1:0] mem     [BUF_DP];
    logic [DATA_WD-1:0] mem_nxt [BUF_DP];
    occ_t               occ_nxt;
    occ_t               widx;

    assign head = mem[0];

    // shift on pop, then land the pushed word behind the last live entry
    always_comb begin
        occ_nxt = occ;
        widx    = occ;
        for (int i = 0; i < BUF_DP; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop && occ != 2'd0) begin
            for (int i = 0; i < BUF_DP - 1; i++) begin
                mem_nxt[i] = mem[i + 1];
            end
            widx = occ - 2'd1;
        end
        if (push && widx != OCC_MAX) begin
            mem_nxt[widx] = push_data;
        end
        unique case ({push, pop})
            2'b10: begin
                if (occ != OCC_MAX) begin
                    occ_nxt = occ + 2'd1;
                end
            end
            2'b01: begin
                if (occ != 2'd0) begin
                    occ_nxt = occ - 2'd1;
                end
            end
            default: occ_nxt = occ;
        endcase
    end

    // storage and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < BUF_DP; i++) begin
                mem[i] <= '0;
            end
        end else begin
            occ <= occ_nxt;
            mem <= mem_nxt;
        end
    end

    a_no_overfill: assert property (
        @(posedge clk) rst || !(push && !pop && occ == OCC_MAX)
    );

    a_no_empty_pop: assert property (
        @(posedge clk) rst || !(pop && occ == 2'd0)
    );

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain: pops the async FIFO and re-times words onto a stream.
// Optional counters under FIFO_RD_DRAIN_STATS_EN (pop_cnt, stall_cnt).
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int CNT_WD  = DEF_CNT_WD
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              drain_en,
    output logic              busy,
`ifdef FIFO_RD_DRAIN_STATS_EN
    output logic [CNT_WD-1:0] pop_cnt,
    output logic [CNT_WD-1:0] stall_cnt,
`endif
    fifo_rd_drain_if.master   bus
);

    if (DATA_WD < 1 || CNT_WD < 1) begin : g_param_chk
        $error("fifo_rd_drain: widths must be positive");
    end

    state_t             state;
    logic               inflight;
    occ_t               occ;
    logic [DATA_WD-1:0] head;
    logic               pop;
    logic               flushed;

    // only registered state and the external empty flag feed the pop,
    // so m_ready never reaches fifo_ren combinationally
    assign bus.fifo_ren = (state == RUN)
                        & ~bus.fifo_empty
                        & has_room(occ, inflight);

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head;
    assign pop         = bus.m_valid & bus.m_ready;
    assign flushed     = (occ == 2'd0) & ~inflight;

    // a pop issued last cycle delivers its data this cycle
    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_ren;
        end
    end

    // run while requested, then flush buffer and inflight word
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (drain_en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!drain_en) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (flushed) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WD (DATA_WD)
    ) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight),
        .push_data (bus.fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

`ifdef FIFO_RD_DRAIN_STATS_EN
    // accepted words and back-pressure cycles, holding at all-ones
    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && !(&pop_cnt)) begin
                pop_cnt <= pop_cnt + CNT_WD'(1);
            end
            if (bus.m_valid && !bus.m_ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_WD'(1);
            end
        end
    end
`endif

    a_hold_stable: assert property (
        @(posedge rclk)
        (!rrst && bus.m_valid && !bus.m_ready)
        |=> (rrst || (bus.m_valid && $stable(bus.m_data)))
    );

endmodule
